// File: rtl/toy_fetch_queue_pkg.sv
// Shared constants and payload types for the instruction fetch queue.
// Package name: toy_pack.
//   FETCH_WRITE_CHANNEL : 32-bit words per fetch line
//   FQ_DEPTH            : fetch queue entries (power of two)
//   FQ_MAX_OUTSTANDING  : fetch requests allowed in flight (power of two)
package toy_pack;

  localparam int unsigned ADDR_WIDTH          = 32;
  localparam int unsigned INST_WIDTH          = 32;
  localparam int unsigned FETCH_WRITE_CHANNEL = 4;
  localparam int unsigned FQ_DEPTH            = 16;
  localparam int unsigned FQ_MAX_OUTSTANDING  = 4;

  // Halfword count from the PC stage, and word count kept per request.
  localparam int unsigned NUM_W    = $clog2(2 * FETCH_WRITE_CHANNEL) + 1;
  localparam int unsigned NWORDS_W = $clog2(FETCH_WRITE_CHANNEL) + 1;
  localparam int unsigned LINE_W   = INST_WIDTH * FETCH_WRITE_CHANNEL;

  // One in-flight fetch request.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [NWORDS_W-1:0]   nwords;
    logic                  kill;
  } fetch_req_info_t;

  // One fetch queue slot.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/toy_fetch_queue_if.sv
// Fetch queue boundary: PC-stage credit/request, memory response,
// flush, and the decode-side instruction handshake.
//   slave  : the fetch queue side
//   master : the surrounding pipeline / bench side
interface toy_fetch_queue_if;
  import toy_pack::*;

  logic                  fetch_nxt_vld;
  logic                  fetch_nxt_rdy;
  logic [ADDR_WIDTH-1:0] fetch_nxt_pc;
  logic [NUM_W-1:0]      fetch_nxt_num;
  logic                  mem_rsp_vld;
  logic [LINE_W-1:0]     mem_rsp_data;
  logic                  flush;
  logic                  inst_vld;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [INST_WIDTH-1:0] inst_data;
  logic                  inst_rdy;

  modport slave (
    output fetch_nxt_vld, inst_vld, inst_pc, inst_data,
    input  fetch_nxt_rdy, fetch_nxt_pc, fetch_nxt_num,
           mem_rsp_vld, mem_rsp_data, flush, inst_rdy
  );

  modport master (
    input  fetch_nxt_vld, inst_vld, inst_pc, inst_data,
    output fetch_nxt_rdy, fetch_nxt_pc, fetch_nxt_num,
           mem_rsp_vld, mem_rsp_data, flush, inst_rdy
  );

endinterface

// File: rtl/toy_fetch_queue_req_fifo.sv
// toy_fetch_req_fifo: in-order record of accepted fetch requests.
//   push/push_info : enqueue an accepted request
//   pop            : dequeue the head when its response arrives
//   kill_all       : mark every live entry as killed (pipeline flush)
//   head_info      : oldest entry; empty, cnt : occupancy
module toy_fetch_req_fifo
  import toy_pack::*;
#(
  parameter int unsigned DEPTH = FQ_MAX_OUTSTANDING
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_req_info_t        push_info,
  input  logic                   pop,
  input  logic                   kill_all,
  output fetch_req_info_t        head_info,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_req_info_t entries [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   slot_off [DEPTH];
  logic [DEPTH-1:0] live;

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    live = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot_off[i] = PW'(i) - rd_ptr;
      live[i]     = {1'b0, slot_off[i]} < cnt_q;
    end
  end

  // Pointers, occupancy and entry storage; a same-cycle push is never killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (kill_all) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (live[i]) begin
            entries[i].kill <= 1'b1;
          end
        end
      end
      if (push) begin
        entries[wr_ptr] <= push_info;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign head_info = entries[rd_ptr];
  assign empty     = (cnt_q == '0);
  assign cnt       = cnt_q;

endmodule

// File: rtl/toy_fetch_queue.sv
// toy_fetch_queue: instruction fetch queue between the fetch PC stage and
// decode. Grants request credit only when a whole line of space is free,
// aligns each in-order memory response to its request PC, and presents one
// instruction per cycle. A flush empties the queue and kills in-flight lines.
//   clk, rst_n : clock, asynchronous active-low reset
//   fq         : toy_fetch_queue_if.slave (credit, response, flush, decode)
// Optional build macro TOY_FETCH_QUEUE_BYPASS_EN: with an empty queue, the
// first word of an arriving response is presented to decode in the same cycle.
module toy_fetch_queue #(
  parameter int unsigned FETCH_WRITE_CHANNEL = toy_pack::FETCH_WRITE_CHANNEL,
  parameter int unsigned FQ_DEPTH            = toy_pack::FQ_DEPTH,
  parameter int unsigned FQ_MAX_OUTSTANDING  = toy_pack::FQ_MAX_OUTSTANDING
) (
  input logic               clk,
  input logic               rst_n,
  toy_fetch_queue_if.slave  fq
);
  import toy_pack::*;

  localparam int unsigned FWC = FETCH_WRITE_CHANNEL;
  localparam int unsigned OW  = $clog2(FWC);
  localparam int unsigned NW  = OW + 1;
  localparam int unsigned PW  = $clog2(FQ_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned OSW = $clog2(FQ_MAX_OUTSTANDING) + 1;
  localparam int unsigned SW  = CW + OSW + OW + 1;

  logic [CW-1:0]   count_q;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic            run_q;
  fq_entry_t       queue_mem [FQ_DEPTH];

  fetch_req_info_t req_push_info;
  fetch_req_info_t req_head;
  logic            req_empty;
  logic [OSW-1:0]  outstanding;
  logic [SW-1:0]   claimed;
  logic            req_fire;
  logic            rsp_pop;
  logic            rsp_wr;
  logic            byp_vld;
  logic            byp_take;
  logic            deq;
  logic [OW-1:0]   line_off;
  logic [NW-1:0]   wr_n;
  logic [ADDR_WIDTH-1:0] line_pc;

  logic [FWC-1:0]  lane_en;
  logic [NW-1:0]   lane_src  [FWC];
  logic [OW-1:0]   lane_word [FWC];
  fq_entry_t       lane_entry [FWC];

  // Credit: occupied plus reserved plus one more full line must fit.
  assign claimed = SW'(count_q) + (SW'(outstanding) << OW) + SW'(FWC);
  assign fq.fetch_nxt_vld = run_q && (claimed <= SW'(FQ_DEPTH))
                            && (outstanding < OSW'(FQ_MAX_OUTSTANDING));
  assign req_fire = fq.fetch_nxt_vld && fq.fetch_nxt_rdy;

  assign req_push_info = '{pc:     fq.fetch_nxt_pc,
                           nwords: NWORDS_W'(fq.fetch_nxt_num >> 1),
                           kill:   1'b0};

  assign rsp_pop = fq.mem_rsp_vld && !req_empty;

  toy_fetch_req_fifo #(
    .DEPTH (FQ_MAX_OUTSTANDING)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_info (req_push_info),
    .pop       (rsp_pop),
    .kill_all  (fq.flush),
    .head_info (req_head),
    .empty     (req_empty),
    .cnt       (outstanding)
  );

  // A response is written only if its request survived and no flush is active.
  assign rsp_wr   = rsp_pop && !req_head.kill && !fq.flush;
  assign line_off = req_head.pc[OW+1:2];
  assign line_pc  = req_head.pc & ~(ADDR_WIDTH'(3));

`ifdef TOY_FETCH_QUEUE_BYPASS_EN
  assign byp_vld = rsp_wr && (count_q == '0) && (req_head.nwords != '0);
`else
  assign byp_vld = 1'b0;
`endif
  assign byp_take = byp_vld && fq.inst_rdy;
  assign deq      = (count_q != '0) && fq.inst_rdy;
  assign wr_n     = rsp_wr ? (NW'(req_head.nwords) - NW'(byp_take)) : '0;

  // Alignment: queue lane j holds response word (pc offset + j + skipped).
  always_comb begin
    lane_en = '0;
    for (int unsigned j = 0; j < FWC; j++) begin
      lane_src[j]        = NW'(j) + NW'(byp_take);
      lane_word[j]       = line_off + OW'(lane_src[j]);
      lane_en[j]         = NW'(j) < wr_n;
      lane_entry[j].pc   = line_pc + (ADDR_WIDTH'(lane_src[j]) << 2);
      lane_entry[j].inst = fq.mem_rsp_data[{lane_word[j], 5'd0} +: INST_WIDTH];
    end
  end

  // Queue storage; slots wrap modulo the depth.
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < FWC; j++) begin
      if (lane_en[j]) begin
        queue_mem[tail_q + PW'(j)] <= lane_entry[j];
      end
    end
  end

  // Occupancy and pointers; flush returns everything to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      run_q <= 1'b1;
      if (fq.flush) begin
        count_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        count_q <= count_q + CW'(wr_n) - CW'(deq);
        head_q  <= head_q + PW'(deq);
        tail_q  <= tail_q + PW'(wr_n);
      end
    end
  end

  // Decode view: queue head, else the bypassed first word, else zero.
  always_comb begin
    fq.inst_vld  = 1'b0;
    fq.inst_pc   = '0;
    fq.inst_data = '0;
    if (count_q != '0) begin
      fq.inst_vld  = 1'b1;
      fq.inst_pc   = queue_mem[head_q].pc;
      fq.inst_data = queue_mem[head_q].inst;
    end else if (byp_vld) begin
      fq.inst_vld  = 1'b1;
      fq.inst_pc   = line_pc;
      fq.inst_data = fq.mem_rsp_data[{line_off, 5'd0} +: INST_WIDTH];
    end
  end

  // A response must always have a matching request.
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    fq.mem_rsp_vld |-> !req_empty);

endmodule

// File: doc/toy_fetch_queue.md
# toy_fetch_queue

Instruction fetch queue that sits directly downstream of the fetch PC stage. It issues fetch-request credit (`fetch_nxt_vld`) only when enough queue space is free. It records each accepted request, aligns the in-order memory response to the request PC, and writes the valid instruction words into a circular queue. It presents one instruction per cycle to decode and discards in-flight data on a pipeline flush.

## Interface

Parameters:
- `FETCH_WRITE_CHANNEL`, default from `toy_pack` (4): 32-bit words per fetch line.
- `FQ_DEPTH`, default 16: queue entries, power of two, ≥ 2·`FETCH_WRITE_CHANNEL`.
- `FQ_MAX_OUTSTANDING`, default 4: in-flight request limit, power of two.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_nxt_vld`  out  1  credit to fetch PC stage; request may issue.
- `fetch_nxt_rdy`  in  1  request accepted this cycle.
- `fetch_nxt_pc`  in  ADDR_WIDTH  request PC.
- `fetch_nxt_num`  in  clog2(2·FWC)+1  halfwords valid from PC to line end.
- `mem_rsp_vld`  in  1  response line valid; responses in request order.
- `mem_rsp_data`  in  32·FWC  line data, word i at bits [32i+31:32i].
- `flush`  in  1  redirect (cancel or trap); kill queue and in-flight requests.
- `inst_vld`  out  1  head instruction valid.
- `inst_pc`  out  ADDR_WIDTH  head PC.
- `inst_data`  out  INST_WIDTH  head instruction.
- `inst_rdy`  in  1  decode consumes head.

## Operation

- Counters:
  - `count`: occupied entries, 0..FQ_DEPTH.
  - `reserved`: entries promised to in-flight requests, FWC each.
  - `outstanding`: requests in flight, 0..FQ_MAX_OUTSTANDING.
- Credit: `fetch_nxt_vld` = (FQ_DEPTH − `count` − `reserved` ≥ FWC) && (`outstanding` < FQ_MAX_OUTSTANDING).
  - A whole line is always reserved, independent of `fetch_nxt_num`.
- Request handshake (`fetch_nxt_vld && fetch_nxt_rdy`):
  - Push {pc, nwords = `fetch_nxt_num`>>1, kill=0} into the request FIFO.
  - `reserved` += FWC; `outstanding` += 1.
  - Only 4-byte-aligned PCs are supported; bit 1 is ignored.
- Response (`mem_rsp_vld`):
  - Pop the request FIFO head. `mem_rsp_vld` with an empty request FIFO is illegal (assertion).
  - `reserved` −= FWC; `outstanding` −= 1.
  - If the entry is not killed and `flush` is low: write `nwords` entries.
    - Entry k takes data word (pc[clog2(FWC)+1:2] + k) and PC = pc + 4k.
    - Entries are written at tail..tail+nwords−1, modulo FQ_DEPTH.
- Dequeue: `inst_vld` = `count` ≠ 0. `inst_vld && inst_rdy` advances head by one.
- Simultaneous enqueue and dequeue: `count` += nwords − 1. Full or wrap never overflows, because reservation guarantees space.
- Flush:
  - `count`, head and tail go to 0 next cycle.
  - All current request-FIFO entries get kill=1.
  - A response in the flush cycle is discarded; its reservation is still released.
  - A request accepted in the flush cycle belongs to the new stream and is pushed with kill=0.
  - `fetch_nxt_vld` in the flush cycle uses pre-flush counters.
  - `inst_vld` is not masked in the flush cycle; a dequeue in that cycle is harmless.
- Arithmetic: all pointers wrap modulo power-of-two depth. `count` is clog2(FQ_DEPTH)+1 bits wide.

## Timing

- Reset values: `fetch_nxt_vld`=0 while `rst_n` is low, then 1 in the first cycle after release. `inst_vld`=0, `inst_pc`=0, `inst_data`=0. All counters are 0 and all kill bits are 0.
- Response at cycle T: entries are visible at T+1 (`inst_vld` at T+1 if the queue was empty).
- Credit freed by a dequeue or response at T is visible at T+1; no combinational path from `inst_rdy` to `fetch_nxt_vld`.
- Response latency from request is ≥ 1 cycle and otherwise arbitrary; ordering is strict.

## Configuration

- `TOY_FETCH_QUEUE_BYPASS_EN` defined:
  - When `count`=0 and an unkilled, non-flushed response arrives, its first word drives `inst_vld`/`inst_pc`/`inst_data` combinationally in cycle T.
  - If `inst_rdy`, that word is not written; nwords−1 entries are written.
- Not defined: no bypass; the first instruction appears at T+1.

## Structure

- `toy_pack` holds:
  - `FQ_DEPTH` and `FQ_MAX_OUTSTANDING`.
  - typedef `fetch_req_info_t` {pc, nwords, kill}.
  - typedef `fq_entry_t` {pc, inst}.
- Sub-module `toy_fetch_req_fifo`: FQ_MAX_OUTSTANDING-deep FIFO of `fetch_req_info_t`, with a `kill_all` input that sets every valid entry's kill bit.
- Top level: credit logic, alignment mux, circular queue.

## Test plan

- After reset, request pc=0x8000_0000, num=8, response words A,B,C,D → outputs (0x8000_0000,A), (0x8000_0004,B), (0x8000_0008,C), (0x8000_000C,D); first at T+1 (T with bypass and empty queue).
- Request pc=0x8000_0008, num=4, response words W0..W3 → exactly two entries: (0x8000_0008,W2), (0x8000_000C,W3).
- Hold `inst_rdy`=0, FQ_DEPTH=16, FWC=4 → four requests accepted, then `fetch_nxt_vld`=0. With no responses it stays 0 after 4 outstanding; it reasserts one cycle after a dequeue frees 4 entries.
- Two requests in flight, flush with a new request pc=0x8000_1000 in the same cycle → both old responses dropped and `outstanding` returns to 1; only 0x8000_1000.. instructions are emitted.
- Flush in the same cycle as a response → no entries written; `count`=0 and `reserved` decreases by FWC.
- Tail at 14, response with nwords=4 and simultaneous dequeue → entries land in slots 14, 15, 0, 1; `count` increases by 3; PC order is preserved across the wrap.
